// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared encodings for the MEM-stage data-memory access controller:
//   - load/store type codes as issued by the decoder
//   - controller state enum
//   - error cause codes raised by the controller
//   - alignment helper used to qualify a new access
// -----------------------------------------------------------------------------
package mem_access_pkg;

    // Load type codes (load_type port)
    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LBU = 3'd1;
    localparam logic [2:0] LOAD_LH  = 3'd2;
    localparam logic [2:0] LOAD_LHU = 3'd3;
    localparam logic [2:0] LOAD_LW  = 3'd4;

    // Store type codes (store_type port)
    localparam logic [1:0] STORE_SB = 2'd0;
    localparam logic [1:0] STORE_SH = 2'd1;
    localparam logic [1:0] STORE_SW = 2'd2;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Error cause reported by the controller in a given cycle
    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_MISALIGN    = 2'd1,
        ERR_BUS_TIMEOUT = 2'd2
    } err_e;

    // Natural alignment check. Bytes are always aligned, halfwords need
    // addr[0]=0, words need addr[1:0]=0. Reserved type codes are treated
    // as word-sized so they can never produce a partial-lane access.
    function automatic logic access_aligned(
        input logic       is_load,
        input logic [2:0] lt,
        input logic [1:0] st,
        input logic [1:0] addr_low
    );
        logic ok;
        ok = 1'b1;
        if (is_load) begin
            case (lt)
                LOAD_LB, LOAD_LBU: ok = 1'b1;
                LOAD_LH, LOAD_LHU: ok = ~addr_low[0];
                LOAD_LW:           ok = (addr_low == 2'b00);
                default:           ok = (addr_low == 2'b00);
            endcase
        end else begin
            case (st)
                STORE_SB: ok = 1'b1;
                STORE_SH: ok = ~addr_low[0];
                STORE_SW: ok = (addr_low == 2'b00);
                default:  ok = (addr_low == 2'b00);
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// -----------------------------------------------------------------------------
// store_lane_align
// Purely combinational store lane steering: produces byte enables and
// lane-replicated write data from the store type and the low address bits.
// Ports:
//   store_type  in  [1:0]  SB / SH / SW code
//   addr_low    in  [1:0]  byte offset within the word
//   store_data  in  [31:0] register value to be stored
//   be          out [3:0]  byte enables, bit i = byte lane i
//   wdata       out [31:0] replicated write data
// -----------------------------------------------------------------------------
module store_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  store_type,
    input  logic [1:0]  addr_low,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned (that would infer a latch).
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (store_type)
            STORE_SB: begin
                be    = 4'b0001 << addr_low;
                wdata = {4{store_data[7:0]}};
            end
            STORE_SH: begin
                be    = addr_low[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                // SW (and reserved codes): full word, defaults apply
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_access_ctrl
// Sequences each MEM-stage data-memory access: checks alignment, latches the
// access, drives a req/ack memory port, stalls the pipeline while the access
// is outstanding, and hands the returned word to the sub-word load extractor.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mem_read, mem_write  MEM-stage instruction is a load / store
//   load_type, store_type, addr, store_data   access description
//   flush                squash the MEM-stage instruction (new starts only)
//   dmem_ack, dmem_rdata memory completion and read word
//   dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata   memory request
//   stall                hold IF..MEM stages
//   load_valid, load_word, split_load_type, split_addr_low   extractor feed
//   misalign_exc, bus_err   one-cycle error pulses
// -----------------------------------------------------------------------------
module mem_stage_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        load_type,
    input  logic [1:0]        store_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    input  logic              flush,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_word,
    output logic [2:0]        split_load_type,
    output logic [1:0]        split_addr_low,
    output logic              misalign_exc,
    output logic              bus_err
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-3:0]   word_addr_q;
    logic                we_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic [31:0]         load_word_q;
    logic [2:0]          split_type_q;
    logic [1:0]          split_low_q;

    logic                req_valid;
    logic                is_load;
    logic                aligned;
    logic                start;
    err_e                err;
    logic [3:0]          st_be;
    logic [31:0]         st_wdata;

    // NOTE: the request qualifier is gated by rst_n so the combinational
    // IDLE outputs (stall, misalign_exc) also drop while reset is held,
    // even if the pipeline keeps presenting an access.
    assign req_valid = rst_n & (mem_read | mem_write) & ~flush;
    // A simultaneous read and write request is handled as a read.
    assign is_load   = mem_read;
    assign aligned   = access_aligned(is_load, load_type, store_type, addr[1:0]);

    store_lane_align u_store_lane_align (
        .store_type (store_type),
        .addr_low   (addr[1:0]),
        .store_data (store_data),
        .be         (st_be),
        .wdata      (st_wdata)
    );

    // Next-state and combinational outputs
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        err        = ERR_NONE;
        stall      = 1'b0;
        dmem_req   = 1'b0;
        load_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (aligned) begin
                        start   = 1'b1;
                        stall   = 1'b1;
                        state_d = ACCESS;
                    end else begin
                        err = ERR_MISALIGN;
                    end
                end
            end
            ACCESS: begin
                dmem_req = 1'b1;
                stall    = 1'b1;
                // Ack wins over timeout on the final cycle.
                if (dmem_ack) begin
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err     = ERR_BUS_TIMEOUT;
                    state_d = IDLE;
                end
            end
            RESP: begin
                load_valid = ~we_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign misalign_exc = (err == ERR_MISALIGN);
    assign bus_err      = (err == ERR_BUS_TIMEOUT);

    // State register and ACCESS cycle counter. The counter is 0 on the first
    // ACCESS cycle and is cleared whenever ACCESS is left.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ACCESS && state_d == ACCESS) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Latched access description, held stable for the whole access.
    // NOTE: datapath registers are reset too, because every output must
    // read 0 while in reset, not just the control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_addr_q  <= '0;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0;
            split_type_q <= 3'd0;
            split_low_q  <= 2'd0;
        end else if (start) begin
            word_addr_q  <= addr[ADDR_W-1:2];
            we_q         <= ~is_load;
            be_q         <= is_load ? 4'b1111 : st_be;
            wdata_q      <= is_load ? 32'h0 : st_wdata;
            split_type_q <= load_type;
            split_low_q  <= addr[1:0];
        end
    end

    // Returned word is captured only on the acknowledging cycle of a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_word_q <= 32'h0;
        end else if (state_q == ACCESS && dmem_ack && !we_q) begin
            load_word_q <= dmem_rdata;
        end
    end

    assign dmem_we         = we_q;
    assign dmem_addr       = {word_addr_q, 2'b00};
    assign dmem_be         = be_q;
    assign dmem_wdata      = wdata_q;
    assign load_word       = load_word_q;
    assign split_load_type = split_type_q;
    assign split_addr_low  = split_low_q;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_access_ctrl
// Directed bench for mem_stage_access_ctrl. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_stage_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read, mem_write, flush, dmem_ack;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] addr, store_data, dmem_rdata;
    logic        dmem_req, dmem_we, stall, load_valid, misalign_exc, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, load_word;
    logic [3:0]  dmem_be;
    logic [2:0]  split_load_type;
    logic [1:0]  split_addr_low;

    int errors = 0;
    int checks = 0;

    // Per-access observations gathered by run_access
    int          r_stall, r_req, r_lv, r_lv_at, r_bus, r_bus_at, r_mis, r_unstable;
    logic [31:0] r_word, r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic [2:0]  r_lt;
    logic [1:0]  r_al;

    mem_stage_access_ctrl #(
        .TIMEOUT_CYCLES (16),
        .ADDR_W         (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .load_type       (load_type),
        .store_type      (store_type),
        .addr            (addr),
        .store_data      (store_data),
        .flush           (flush),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .stall           (stall),
        .load_valid      (load_valid),
        .load_word       (load_word),
        .split_load_type (split_load_type),
        .split_addr_low  (split_addr_low),
        .misalign_exc    (misalign_exc),
        .bus_err         (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Runs n_cycles cycles starting from the cycle whose inputs the caller
    // has just driven. From the second cycle on, the MEM-stage inputs are
    // withdrawn/scrambled so the latched request must carry the access.
    // ack_at = ACCESS cycle number (1-based) that gets dmem_ack, 0 = never.
    task automatic run_access(input int ack_at, input logic [31:0] rdata,
                              input logic flush_mid, input int n_cycles);
        int acc;
        acc = 0;
        r_stall = 0; r_req = 0; r_lv = 0; r_lv_at = -1; r_bus = 0; r_bus_at = -1;
        r_mis = 0; r_unstable = 0;
        r_word = '0; r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0; r_lt = '0; r_al = '0;
        for (int c = 0; c < n_cycles; c++) begin
            if (c == 1) begin
                mem_read   = 1'b0;
                mem_write  = 1'b0;
                addr       = ~addr;
                store_data = ~store_data;
                load_type  = 3'd7;
                store_type = 2'd3;
                flush      = flush_mid;
            end
            if (dmem_req) begin
                acc++;
                dmem_ack   = (acc == ack_at);
                dmem_rdata = dmem_ack ? rdata : 32'hA5A5_A5A5;
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = 32'h5A5A_5A5A;
            end
            @(negedge clk);
            if (stall) r_stall++;
            if (misalign_exc) r_mis++;
            if (bus_err) begin r_bus++; r_bus_at = acc; end
            if (load_valid) begin
                r_lv++; r_lv_at = c;
                r_word = load_word; r_lt = split_load_type; r_al = split_addr_low;
            end
            if (dmem_req) begin
                r_req++;
                if (acc == 1) begin
                    r_addr = dmem_addr; r_be = dmem_be; r_wdata = dmem_wdata; r_we = dmem_we;
                end else if (dmem_addr !== r_addr || dmem_be !== r_be ||
                             dmem_wdata !== r_wdata || dmem_we !== r_we) begin
                    r_unstable++;
                end
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        mem_read = 0; mem_write = 0; flush = 0; dmem_ack = 0;
        load_type = 0; store_type = 0; addr = 0; store_data = 0; dmem_rdata = 0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_stall",  32'(stall), 0);
        check("rst_req",    32'(dmem_req), 0);
        check("rst_lv",     32'(load_valid), 0);
        check("rst_word",   load_word, 0);
        check("rst_addr",   dmem_addr, 0);
        check("rst_be",     32'(dmem_be), 0);
        check("rst_split",  32'({split_load_type, split_addr_low}), 0);
        @(posedge clk); #1;

        // LW 0x100, ack on first ACCESS cycle
        mem_read = 1; load_type = 3'd4; addr = 32'h100;
        run_access(1, 32'hDEAD_BEEF, 1'b0, 6);
        check("lw_stall",   r_stall, 2);
        check("lw_req",     r_req, 1);
        check("lw_addr",    r_addr, 32'h100);
        check("lw_be",      32'(r_be), 32'hF);
        check("lw_we",      32'(r_we), 0);
        check("lw_lv",      r_lv, 1);
        check("lw_lv_at",   r_lv_at, 2);
        check("lw_word",    r_word, 32'hDEAD_BEEF);
        check("lw_type",    32'(r_lt), 4);
        check("lw_low",     32'(r_al), 0);

        // SB 0x203, ack on third ACCESS cycle
        mem_write = 1; store_type = 2'd0; addr = 32'h203; store_data = 32'h1234_5678;
        run_access(3, 32'h0, 1'b0, 7);
        check("sb_stall",   r_stall, 4);
        check("sb_req",     r_req, 3);
        check("sb_we",      32'(r_we), 1);
        check("sb_be",      32'(r_be), 32'b1000);
        check("sb_wdata",   r_wdata, 32'h7878_7878);
        check("sb_addr",    r_addr, 32'h200);
        check("sb_stable",  r_unstable, 0);
        check("sb_lv",      r_lv, 0);

        // LH 0x101 misaligned, then the same access flushed
        mem_read = 1; load_type = 3'd2; addr = 32'h101;
        run_access(0, 32'h0, 1'b0, 4);
        check("mis_pulse",  r_mis, 1);
        check("mis_req",    r_req, 0);
        check("mis_stall",  r_stall, 0);
        mem_read = 1; load_type = 3'd2; addr = 32'h101; flush = 1;
        run_access(0, 32'h0, 1'b1, 4);
        check("misf_pulse", r_mis, 0);
        check("misf_req",   r_req, 0);

        // LW never acked: timeout
        mem_read = 1; load_type = 3'd4; addr = 32'h80;
        run_access(0, 32'h0, 1'b0, 20);
        check("to_bus",     r_bus, 1);
        check("to_bus_at",  r_bus_at, 16);
        check("to_req",     r_req, 16);
        check("to_stall",   r_stall, 17);
        check("to_lv",      r_lv, 0);

        // LW acked on the final timeout cycle: no bus error
        mem_read = 1; load_type = 3'd4; addr = 32'h84;
        run_access(16, 32'h0BAD_CAFE, 1'b0, 20);
        check("late_bus",   r_bus, 0);
        check("late_lv",    r_lv, 1);
        check("late_word",  r_word, 32'h0BAD_CAFE);
        check("late_stall", r_stall, 17);

        // SH 0x402 with flush raised during ACCESS
        mem_write = 1; store_type = 2'd1; addr = 32'h402; store_data = 32'h0000_ABCD;
        run_access(2, 32'h0, 1'b1, 6);
        check("sh_be",      32'(r_be), 32'b1100);
        check("sh_wdata",   r_wdata, 32'hABCD_ABCD);
        check("sh_addr",    r_addr, 32'h400);
        check("sh_req",     r_req, 2);
        check("sh_stall",   r_stall, 3);

        // SW 0x10 and a read+write request (treated as LW)
        mem_write = 1; store_type = 2'd2; addr = 32'h10; store_data = 32'hCAFE_BABE;
        run_access(1, 32'h0, 1'b0, 5);
        check("sw_be",      32'(r_be), 32'hF);
        check("sw_wdata",   r_wdata, 32'hCAFE_BABE);
        mem_read = 1; mem_write = 1; load_type = 3'd4; store_type = 2'd0;
        addr = 32'h20; store_data = 32'h1111_2222;
        run_access(1, 32'h3333_4444, 1'b0, 5);
        check("rw_we",      32'(r_we), 0);
        check("rw_wdata",   r_wdata, 0);
        check("rw_lv",      r_lv, 1);
        check("rw_word",    r_word, 32'h3333_4444);

        // Asynchronous reset in the middle of ACCESS
        mem_read = 1; load_type = 3'd4; addr = 32'h300;
        @(negedge clk);
        check("ar_start",   32'(stall), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("ar_req_on",  32'(dmem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_req",     32'(dmem_req), 0);
        check("ar_stall",   32'(stall), 0);
        check("ar_pulses",  32'({load_valid, misalign_exc, bus_err}), 0);
        check("ar_addr",    dmem_addr, 0);
        check("ar_be",      32'(dmem_be), 0);
        @(posedge clk); #1;
        mem_read = 0; rst_n = 1'b1;
        @(posedge clk); #1;

        // LBU 0x7 after reset
        mem_read = 1; load_type = 3'd1; addr = 32'h7;
        run_access(1, 32'h0000_00F1, 1'b0, 5);
        check("lbu_stall",  r_stall, 2);
        check("lbu_addr",   r_addr, 32'h4);
        check("lbu_be",     32'(r_be), 32'hF);
        check("lbu_lv",     r_lv, 1);
        check("lbu_word",   r_word, 32'h0000_00F1);
        check("lbu_type",   32'(r_lt), 1);
        check("lbu_low",    32'(r_al), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
